// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: cache geometry default, the JAL
// opcode, FSM state encodings, boolean constants, the registered queue-push
// bundle and the static next-PC helper.
package inst_fetch_pkg;

    localparam int unsigned ICACHE_IDX_W_DEF = 8;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // One registered push toward the instruction queue.
    typedef struct packed {
        logic        flag;
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_out_t;

    // Static prediction: JAL jumps to pc + J-immediate, everything else
    // falls through to pc + 4. Both wrap at 2^32.
    function automatic logic [31:0] npc_calc(input logic [31:0] pc,
                                             input logic [31:0] inst);
        logic [31:0] imm;
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        if (inst[6:0] == OPCODE_JAL) begin
            return pc + imm;
        end
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line. Lookup is fully
// combinational; fills are written on the clock edge. Only the valid bits are
// reset, so an asynchronous reset empties the cache.
module inst_fetch_icache_dm
    import inst_fetch_pkg::*;
#(
    parameter int unsigned IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] lookup_addr,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        fill_en,
    input  logic [31:2] fill_addr,
    input  logic [31:0] fill_data
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] fl_idx;
    logic [TAG_W-1:0] fl_tag;

    assign lk_idx = lookup_addr[IDX_W+1:2];
    assign lk_tag = lookup_addr[31:IDX_W+2];
    assign fl_idx = fill_addr[IDX_W+1:2];
    assign fl_tag = fill_addr[31:IDX_W+2];

    // Same-cycle valid/tag compare and data read for the current fetch PC.
    always_comb begin
        hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        rd_data = data_q[lk_idx];
    end

    // A fill marks its line valid; nothing ever invalidates a line.
    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fl_idx] = TRUE;
        end
    end

    // Valid bits: cleared asynchronously so the cache is empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage: written only by fills, not reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fl_idx]  <= fl_tag;
            data_q[fl_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: holds the fetch PC, looks it up in the direct-mapped icache,
// requests misses from the memory controller one at a time, and pushes one
// {inst, PC} pair per cycle to the instruction queue. Roll redirects fetch;
// an outstanding miss still completes and fills the cache.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = ICACHE_IDX_W_DEF,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        roll,
    input  logic [31:0] roll_pc,
    input  logic        IQ_full,
    output logic        IF_flag,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_PC,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [0:0]  state_q;
    logic [0:0]  state_d;
    fetch_out_t  out_q;
    fetch_out_t  out_d;
    logic        mc_req_q;
    logic        mc_req_d;
    logic [31:0] mc_addr_q;
    logic [31:0] mc_addr_d;

    logic        hit;
    logic [31:0] line_data;
    logic        fill_en;
    logic [31:0] npc;

    // A fill only happens when the returned word is actually accepted.
    assign fill_en = rdy && (state_q == WAIT) && MC_done;
    assign npc     = npc_calc(pc_q, line_data);

    inst_fetch_icache_dm #(
        .IDX_W(ICACHE_IDX_W)
    ) u_icache (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_addr(pc_q[31:2]),
        .hit        (hit),
        .rd_data    (line_data),
        .fill_en    (fill_en),
        .fill_addr  (mc_addr_q[31:2]),
        .fill_data  (MC_data)
    );

    // Next-state: roll wins everywhere, but in WAIT it only retargets the PC
    // while the pending request runs to completion.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        out_d     = out_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        if (rdy) begin
            out_d.flag = FALSE;
            if (state_q == IDLE) begin
                if (roll) begin
                    pc_d = roll_pc;
                end else if (hit) begin
                    if (!IQ_full) begin
                        out_d.flag = TRUE;
                        out_d.inst = line_data;
                        out_d.pc   = pc_q;
                        pc_d       = npc;
                    end
                end else begin
                    mc_req_d  = TRUE;
                    mc_addr_d = {pc_q[31:2], 2'b00};
                    state_d   = WAIT;
                end
            end else begin
                if (MC_done) begin
                    mc_req_d = FALSE;
                    state_d  = IDLE;
                end
                if (roll) begin
                    pc_d = roll_pc;
                end
            end
        end
    end

    // Architectural state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            state_q   <= IDLE;
            out_q     <= '0;
            mc_req_q  <= FALSE;
            mc_addr_q <= '0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            out_q     <= out_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    assign IF_flag = out_q.flag;
    assign IF_inst = out_q.inst;
    assign IF_PC   = out_q.pc;
    assign MC_req  = mc_req_q;
    assign MC_addr = mc_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a PC/memory/cache-contents model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        roll = 1'b0;
    logic [31:0] roll_pc = 32'h0;
    logic        IQ_full = 1'b0;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done = 1'b0;
    logic [31:0] MC_data = 32'h0;

    inst_fetch #(
        .ICACHE_IDX_W(8),
        .RESET_PC    (32'h0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdy    (rdy),
        .roll   (roll),
        .roll_pc(roll_pc),
        .IQ_full(IQ_full),
        .IF_flag(IF_flag),
        .IF_inst(IF_inst),
        .IF_PC  (IF_PC),
        .MC_req (MC_req),
        .MC_addr(MC_addr),
        .MC_done(MC_done),
        .MC_data(MC_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: a JAL at 0x10, NOPs everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0100006F : 32'h00000013;
    endfunction

    // Reference next PC assembled from the J-type field layout.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        if (inst[6:0] != 7'h6F) return pc + 32'd4;
        imm = (inst[31] ? 32'hFFF00000 : 32'h0)
            | ({24'h0, inst[19:12]} << 12)
            | ({31'h0, inst[20]} << 11)
            | ({22'h0, inst[30:21]} << 1);
        return pc + imm;
    endfunction

    // Model state: cache contents keyed by line index, storing word address.
    logic        m_wait, m_flag, m_req;
    logic [31:0] m_pc, m_inst, m_ipc, m_addr;
    logic [29:0] c_line [int];
    logic [31:0] c_data [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_wait = 1'b0; m_flag = 1'b0; m_inst = 32'h0;
            m_ipc = 32'h0; m_req = 1'b0; m_addr = 32'h0;
            c_line.delete(); c_data.delete();
        end else if (rdy) begin
            int idx;
            bit hit;
            idx = int'((m_pc >> 2) % 256);
            hit = c_line.exists(idx) && (c_line[idx] == m_pc[31:2]);
            m_flag = 1'b0;
            if (m_wait) begin
                if (MC_done) begin
                    c_line[int'((m_addr >> 2) % 256)] = m_addr[31:2];
                    c_data[int'((m_addr >> 2) % 256)] = MC_data;
                    m_req = 1'b0;
                    m_wait = 1'b0;
                end
                if (roll) m_pc = roll_pc;
            end else if (roll) begin
                m_pc = roll_pc;
            end else if (hit) begin
                if (!IQ_full) begin
                    m_flag = 1'b1;
                    m_inst = c_data[idx];
                    m_ipc = m_pc;
                    m_pc = ref_next(m_pc, c_data[idx]);
                end
            end else begin
                m_req = 1'b1;
                m_addr = {m_pc[31:2], 2'b00};
                m_wait = 1'b1;
            end
        end
    end

    logic [31:0] pushes [$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("IF_flag", {31'h0, IF_flag}, {31'h0, m_flag});
        check("IF_inst", IF_inst, m_inst);
        check("IF_PC",   IF_PC,   m_ipc);
        check("MC_req",  {31'h0, MC_req}, {31'h0, m_req});
        check("MC_addr", MC_addr, m_addr);
        if (IF_flag) pushes.push_back(IF_PC);
    end

    // Memory controller responder with two-cycle latency when enabled.
    bit auto_mc = 1'b0;
    int lat = 0;
    always @(negedge clk) begin
        if (auto_mc) begin
            if (MC_done) begin
                MC_done = 1'b0;
            end else if (MC_req && rdy) begin
                lat++;
                if (lat >= 2) begin
                    MC_done = 1'b1;
                    MC_data = mem_word(MC_addr);
                    lat = 0;
                end
            end
        end
    end

    task automatic mc_pulse(input logic [31:0] d);
        MC_done = 1'b1;
        MC_data = d;
        @(negedge clk);
        MC_done = 1'b0;
    endtask

    task automatic wait_push(input string name, input logic [31:0] pc, input int maxc);
        bit found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (IF_flag && IF_PC == pc) found = 1'b1;
        end
        check(name, {31'h0, found}, 32'h1);
    endtask

    task automatic wait_any_push(input string name, input logic [31:0] pc, input int maxc);
        bit found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (IF_flag) found = 1'b1;
        end
        check({name, "_seen"}, {31'h0, found}, 32'h1);
        check(name, IF_PC, pc);
    endtask

    initial begin
        bit saw40;
        // Pin the reference next-PC rules with literal values.
        check("model_jal",  ref_next(32'h10, 32'h0100006F), 32'h20);
        check("model_wrap", ref_next(32'hFFFFFFFC, 32'h13), 32'h0);
        check("model_jneg", ref_next(32'h100, 32'hFFDFF06F), 32'hFC);

        // Cold start.
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, MC_req}, 32'h0);
        check("rst_flag", {31'h0, IF_flag}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cold_req", {31'h0, MC_req}, 32'h1);
        check("cold_addr", MC_addr, 32'h0);
        mc_pulse(32'h00000013);
        @(negedge clk);
        check("cold_flag", {31'h0, IF_flag}, 32'h1);
        check("cold_inst", IF_inst, 32'h00000013);
        check("cold_pc", IF_PC, 32'h0);

        // Fill sequentially through the JAL.
        auto_mc = 1'b1;
        wait_push("push_jal", 32'h10, 60);
        check("jal_inst", IF_inst, 32'h0100006F);
        wait_any_push("jal_target", 32'h20, 30);
        auto_mc = 1'b0;
        roll = 1'b1; roll_pc = 32'h0;
        @(negedge clk);
        check("roll_nopush", {31'h0, IF_flag}, 32'h0);
        roll = 1'b0;

        // Hot loop: four back-to-back hits.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hot_flag", {31'h0, IF_flag}, 32'h1);
            check("hot_pc", IF_PC, 32'(4 * i));
            check("hot_noreq", {31'h0, MC_req}, 32'h0);
        end

        // Backpressure.
        roll = 1'b1; roll_pc = 32'h0;
        @(negedge clk);
        roll = 1'b0;
        @(negedge clk);
        check("bp_first", IF_PC, 32'h0);
        IQ_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {31'h0, IF_flag}, 32'h0);
        end
        IQ_full = 1'b0;
        @(negedge clk);
        check("bp_resume_flag", {31'h0, IF_flag}, 32'h1);
        check("bp_resume_pc", IF_PC, 32'h4);
        @(negedge clk);
        check("bp_next_pc", IF_PC, 32'h8);

        // Roll during a miss.
        roll = 1'b1; roll_pc = 32'h40;
        @(negedge clk);
        roll = 1'b0;
        @(negedge clk);
        check("miss40_req", {31'h0, MC_req}, 32'h1);
        check("miss40_addr", MC_addr, 32'h40);
        roll = 1'b1; roll_pc = 32'h100;
        @(negedge clk);
        roll = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("roll_wait_req", {31'h0, MC_req}, 32'h1);
            @(negedge clk);
        end
        mc_pulse(mem_word(32'h40));
        @(negedge clk);
        check("miss100_req", {31'h0, MC_req}, 32'h1);
        check("miss100_addr", MC_addr, 32'h100);
        mc_pulse(32'h00000013);
        @(negedge clk);
        check("push100", IF_PC, 32'h100);
        saw40 = 1'b0;
        foreach (pushes[i]) if (pushes[i] == 32'h40) saw40 = 1'b1;
        check("no_push40", {31'h0, saw40}, 32'h0);
        roll = 1'b1; roll_pc = 32'h40;
        @(negedge clk);
        roll = 1'b0;
        @(negedge clk);
        check("filled40_flag", {31'h0, IF_flag}, 32'h1);
        check("filled40_pc", IF_PC, 32'h40);
        check("filled40_noreq", {31'h0, MC_req}, 32'h0);

        // rdy low with MC_done pulsed mid-WAIT.
        roll = 1'b1; roll_pc = 32'h200;
        @(negedge clk);
        roll = 1'b0;
        @(negedge clk);
        check("miss200_req", {31'h0, MC_req}, 32'h1);
        rdy = 1'b0; MC_done = 1'b1; MC_data = 32'hDEADBEEF;
        @(negedge clk);
        MC_done = 1'b0;
        check("rdy_hold_req", {31'h0, MC_req}, 32'h1);
        @(negedge clk);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_ignored_req", {31'h0, MC_req}, 32'h1);
            check("done_ignored_flag", {31'h0, IF_flag}, 32'h0);
        end

        // Asynchronous reset mid-WAIT.
        #3 rst_n = 1'b0;
        #1;
        check("areset_req", {31'h0, MC_req}, 32'h0);
        check("areset_flag", {31'h0, IF_flag}, 32'h0);
        check("areset_addr", MC_addr, 32'h0);
        check("areset_pc", IF_PC, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_req", {31'h0, MC_req}, 32'h1);
        check("restart_addr", MC_addr, 32'h0);
        auto_mc = 1'b1;
        wait_push("restart_push0", 32'h0, 20);
        check("restart_inst", IF_inst, 32'h00000013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
